// File: rtl/clock_div_bank_if.sv
// rtl/clock_div_bank_if.sv - divisor update request/ready bus for clock_div_bank
interface clock_div_bank_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 8
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clock_div_bank.sv
// rtl/clock_div_bank.sv - NCH-channel programmable clock divider with glitch-free
// divisor updates, clean stop, phase align and staged per-channel reset release
module clock_div_bank #(
  parameter int NCH        = 4,
  parameter int WIDTH      = 8,
  parameter int RST_STAGES = 3,
  parameter int DIV_RESET  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_reset,
  input  logic [NCH-1:0]   ch_en,
  input  logic             align,
  clock_div_bank_if.slave  cfg,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   resetb_sync
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [WIDTH-1:0] DIV_INIT = WIDTH'(DIV_RESET);
  localparam logic [3:0]       RST_INIT = 4'(RST_STAGES);

  logic [WIDTH-1:0] cnt     [NCH];
  logic [WIDTH-1:0] div_act [NCH];
  logic [WIDTH-1:0] div_stg [NCH];
  logic [3:0]       rcnt    [NCH];
  logic [NCH-1:0]   pending;
  logic [NCH-1:0]   accept;
  logic [NCH-1:0]   terminal;
  logic [NCH-1:0]   rise;
  logic [(1<<CHW)-1:0] pend_pad;

  // Channel indices past NCH read as never pending, so such requests complete and vanish.
  always_comb begin
    pend_pad = '0;
    for (int i = 0; i < NCH; i++) pend_pad[i] = pending[i];
  end

  assign cfg.cfg_ready = ~pend_pad[cfg.cfg_ch];

  always_comb begin
    accept   = '0;
    terminal = '0;
    rise     = '0;
    for (int i = 0; i < NCH; i++) begin
      accept[i]   = cfg.cfg_valid & cfg.cfg_ready & (cfg.cfg_ch == CHW'(i));
      terminal[i] = (cnt[i] == div_act[i]);
      rise[i]     = ~align & ch_en[i] & ~clk_out[i] & terminal[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i]     <= '0;
        div_act[i] <= DIV_INIT;
        div_stg[i] <= DIV_INIT;
        rcnt[i]    <= RST_INIT;
      end
      pending     <= '0;
      clk_out     <= '0;
      tick        <= '0;
      resetb_sync <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        // Divisor changes only where a fresh half-period starts: align, idle, or terminal.
        if (align || (!ch_en[i] && !clk_out[i])) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          tick[i]    <= 1'b0;
          if (pending[i]) begin
            div_act[i] <= div_stg[i];
            pending[i] <= 1'b0;
          end
        end else if (terminal[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= ~clk_out[i];
          tick[i]    <= ~clk_out[i];
          if (pending[i]) begin
            div_act[i] <= div_stg[i];
            pending[i] <= 1'b0;
          end
        end else begin
          cnt[i]  <= cnt[i] + WIDTH'(1);
          tick[i] <= 1'b0;
        end

        if (accept[i]) begin
          div_stg[i] <= cfg.cfg_div;
          pending[i] <= 1'b1;
        end

        if (ext_reset) begin
          rcnt[i]        <= RST_INIT;
          resetb_sync[i] <= 1'b0;
        end else if (rise[i] && (rcnt[i] != 4'd0)) begin
          rcnt[i]        <= rcnt[i] - 4'd1;
          resetb_sync[i] <= (rcnt[i] == 4'd1);
        end else begin
          resetb_sync[i] <= (rcnt[i] == 4'd0);
        end
      end
    end
  end
endmodule
